// File: rtl/regfile_writeback_unit.sv
// Write-back queue feeding the register file write port, with pending-value forwarding.
// Optional ZERO_REG_PROTECT_EN drops and hides writes to r0.
module regfile_writeback_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_valid,
   output logic                      wb_ready,
   input  logic                      wb_regwrite,
   input  logic [ADDR_W-1:0]         wb_rd,
   input  logic [DATA_W-1:0]         wb_data,
   input  logic                      wr_stall,
   output logic [DATA_W-1:0]         S3_WriteData,
   output logic [ADDR_W-1:0]         S3_WriteSelect,
   output logic                      S3_WriteEnable,
   input  logic [ADDR_W-1:0]         fwd_sel1,
   input  logic [ADDR_W-1:0]         fwd_sel2,
   output logic                      fwd_hit1,
   output logic                      fwd_hit2,
   output logic [DATA_W-1:0]         fwd_data1,
   output logic [DATA_W-1:0]         fwd_data2,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] rd_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [PTR_W:0]    count;
   logic              full;
   logic              keep;
   logic              push;
   logic              pop;

   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign wb_ready  = !full && !rst;
   assign occupancy = count;

`ifdef ZERO_REG_PROTECT_EN
   assign keep = wb_regwrite && (wb_rd != '0);
`else
   assign keep = wb_regwrite;
`endif

   assign push = wb_valid && wb_ready && keep;
   assign pop  = (count != '0) && !wr_stall;

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wptr]   <= wb_rd;
         data_q[wptr] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         S3_WriteEnable <= 1'b0;
         S3_WriteData   <= '0;
         S3_WriteSelect <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         S3_WriteEnable <= pop;
         if (pop) begin
            S3_WriteData   <= data_q[rptr];
            S3_WriteSelect <= rd_q[rptr];
         end
      end
   end

   // Oldest candidates first so the newest match overwrites.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      if (S3_WriteEnable && S3_WriteSelect == fwd_sel1) begin
         fwd_hit1  = 1'b1;
         fwd_data1 = S3_WriteData;
      end
      if (S3_WriteEnable && S3_WriteSelect == fwd_sel2) begin
         fwd_hit2  = 1'b1;
         fwd_data2 = S3_WriteData;
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i < int'(count)) begin
            if (rd_q[wptr - PTR_W'(i + 1)] == fwd_sel1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_q[wptr - PTR_W'(i + 1)];
            end
            if (rd_q[wptr - PTR_W'(i + 1)] == fwd_sel2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_q[wptr - PTR_W'(i + 1)];
            end
         end
      end
`ifdef ZERO_REG_PROTECT_EN
      if (fwd_sel1 == '0) begin
         fwd_hit1  = 1'b0;
         fwd_data1 = '0;
      end
      if (fwd_sel2 == '0) begin
         fwd_hit2  = 1'b0;
         fwd_data2 = '0;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Scoreboard bench for regfile_writeback_unit: directed pushes, monitor checks
// every register-file write against the expected in-order queue.
module tb_regfile_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wr_stall;
   logic [31:0] S3_WriteData;
   logic [4:0]  S3_WriteSelect;
   logic        S3_WriteEnable;
   logic [4:0]  fwd_sel1;
   logic [4:0]  fwd_sel2;
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [31:0] fwd_data1;
   logic [31:0] fwd_data2;
   logic [2:0]  occupancy;

   logic [31:0] rf [32];
   logic [36:0] exp_q [$];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   regfile_writeback_unit dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .wr_stall(wr_stall),
      .S3_WriteData(S3_WriteData), .S3_WriteSelect(S3_WriteSelect),
      .S3_WriteEnable(S3_WriteEnable),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .occupancy(occupancy)
   );

   always @(posedge clk)
      if (S3_WriteEnable) rf[S3_WriteSelect] <= S3_WriteData;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [36:0] e;
      if (S3_WriteEnable) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write got sel=%0d data=%h want none",
                     S3_WriteSelect, S3_WriteData);
         end else begin
            e = exp_q.pop_front();
            chk("wr_sel", 32'(S3_WriteSelect), 32'(e[36:32]));
            chk("wr_data", S3_WriteData, e[31:0]);
         end
      end
   end

   task automatic offer(input logic rw, input logic [4:0] rd,
                        input logic [31:0] d, output logic acc,
                        output logic [2:0] occ);
      logic kept;
      wb_valid    = 1'b1;
      wb_regwrite = rw;
      wb_rd       = rd;
      wb_data     = d;
      @(negedge clk);
      acc = wb_ready;
      occ = occupancy;
`ifdef ZERO_REG_PROTECT_EN
      kept = rw && (rd != 5'd0);
`else
      kept = rw;
`endif
      if (acc && kept) exp_q.push_back({rd, d});
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   initial begin
      logic       acc;
      logic [2:0] occ;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rst = 1'b1; wb_valid = 1'b0; wb_regwrite = 1'b0;
      wb_rd = '0; wb_data = '0; wr_stall = 1'b0;
      fwd_sel1 = 5'd3; fwd_sel2 = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(wb_ready), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_we", 32'(S3_WriteEnable), 32'd0);
      chk("rst_data", S3_WriteData, 32'd0);
      chk("rst_sel", 32'(S3_WriteSelect), 32'd0);
      chk("rst_hit", 32'({fwd_hit1, fwd_hit2}), 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // single write and latency
      offer(1'b1, 5'd3, 32'hDEADBEEF, acc, occ);
      chk("single_acc", 32'(acc), 32'd1);
      @(negedge clk);
      chk("single_occ", 32'(occupancy), 32'd1);
      chk("single_we0", 32'(S3_WriteEnable), 32'd0);
      @(negedge clk);
      chk("single_we1", 32'(S3_WriteEnable), 32'd1);
      chk("single_sel", 32'(S3_WriteSelect), 32'd3);
      chk("single_data", S3_WriteData, 32'hDEADBEEF);
      @(negedge clk);
      chk("single_we_off", 32'(S3_WriteEnable), 32'd0);
      chk("single_rf", rf[3], 32'hDEADBEEF);

      // fill under stall
      @(posedge clk); #1; wr_stall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         offer(1'b1, 5'(i), 32'(i * 17), acc, occ);
         chk("fill_acc", 32'(acc), 32'd1);
      end
      @(negedge clk);
      chk("fill_occ", 32'(occupancy), 32'd4);
      chk("fill_ready", 32'(wb_ready), 32'd0);
      @(posedge clk); #1;
      offer(1'b1, 5'd5, 32'h55, acc, occ);
      chk("fill_5th_acc", 32'(acc), 32'd0);
      wr_stall = 1'b0;
      @(negedge clk);
      chk("fill_held", 32'(S3_WriteEnable), 32'd0);
      @(negedge clk);
      chk("fill_first_sel", 32'(S3_WriteSelect), 32'd1);
      chk("fill_occ3", 32'(occupancy), 32'd3);
      chk("fill_ready1", 32'(wb_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("fill_last_we", 32'(S3_WriteEnable), 32'd1);
      chk("fill_occ0", 32'(occupancy), 32'd0);
      @(negedge clk);

      // forwarding priority
      @(posedge clk); #1; wr_stall = 1'b1;
      offer(1'b1, 5'd7, 32'hA, acc, occ);
      offer(1'b1, 5'd7, 32'hB, acc, occ);
      fwd_sel1 = 5'd7; fwd_sel2 = 5'd8;
      @(negedge clk);
      chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
      chk("fwd_data1", fwd_data1, 32'hB);
      chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
      chk("fwd_data2", fwd_data2, 32'd0);
      @(posedge clk); #1; wr_stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("fwd_mid_data", fwd_data1, 32'hB);
      @(negedge clk);
      chk("fwd_out_hit", 32'(fwd_hit1), 32'd1);
      chk("fwd_out_data", fwd_data1, 32'hB);
      @(negedge clk);
      chk("fwd_gone", 32'(fwd_hit1), 32'd0);

      // drop and r0
      @(posedge clk); #1;
      offer(1'b0, 5'd5, 32'h1234, acc, occ);
      chk("drop_acc", 32'(acc), 32'd1);
      @(negedge clk);
      chk("drop_occ", 32'(occupancy), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      offer(1'b1, 5'd0, 32'h55, acc, occ);
      repeat (4) @(negedge clk);
`ifdef ZERO_REG_PROTECT_EN
      chk("r0_rf", rf[0], 32'd0);
`else
      chk("r0_rf", rf[0], 32'h55);
`endif

      // reset mid-operation
      @(posedge clk); #1; wr_stall = 1'b1;
      offer(1'b1, 5'd9, 32'h90, acc, occ);
      offer(1'b1, 5'd10, 32'hA0, acc, occ);
      offer(1'b1, 5'd11, 32'hB0, acc, occ);
      fwd_sel1 = 5'd10; fwd_sel2 = 5'd11;
      @(negedge clk);
      chk("pre_rst_hit", 32'(fwd_hit1), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_ready", 32'(wb_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; wr_stall = 1'b0;
      @(negedge clk);
      chk("post_rst_occ", 32'(occupancy), 32'd0);
      chk("post_rst_hit", 32'({fwd_hit1, fwd_hit2}), 32'd0);
      chk("post_rst_we", 32'(S3_WriteEnable), 32'd0);
      repeat (4) @(negedge clk);

      // streaming
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         offer(1'b1, 5'(i % 32), 32'h1000 + 32'(i), acc, occ);
         chk("stream_ready", 32'(acc), 32'd1);
         chk("stream_occ_le1", 32'(occ <= 3'd1), 32'd1);
      end
      repeat (4) @(negedge clk);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
